// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data port has priority, instruction fetch is
// guaranteed service after STARVE_MAX consecutive data grants. One-cycle read latency.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_wren,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_data_out
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [2:0]  FETCH_FUNCT3 = 3'b010;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IF    = 2'd1,
    OWN_DLOAD = 2'd2
  } owner_e;

  owner_e           pend_owner;
  owner_e           pend_owner_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic             starved_c;

  // Grant decision; nothing is granted while reset is held low
  always_comb begin
    starved_c = (starve_cnt == CNT_W'(STARVE_MAX));
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if (reset) begin
      if_gnt = if_req & (~d_req | starved_c);
      d_gnt  = d_req & ~if_gnt;
    end
  end

  // Memory port follows the granted requester, idles at zero
  always_comb begin
    mem_wren    = 1'b0;
    mem_address = 32'd0;
    mem_data_in = 32'd0;
    mem_funct3  = 3'd0;
    if (if_gnt) begin
      mem_address = if_addr;
      mem_funct3  = FETCH_FUNCT3;
    end else if (d_gnt) begin
      mem_wren    = d_we;
      mem_address = d_addr;
      mem_data_in = d_wdata;
      mem_funct3  = d_funct3;
    end
  end

  // Next-state: who owns next cycle's read data, and fetch starvation count
  always_comb begin
    pend_owner_nxt = OWN_NONE;
    starve_cnt_nxt = starve_cnt;
    if (if_gnt) begin
      pend_owner_nxt = OWN_IF;
    end else if (d_gnt && !d_we) begin
      pend_owner_nxt = OWN_DLOAD;
    end
    if (!if_req || if_gnt) begin
      starve_cnt_nxt = '0;
    end else if (d_gnt && !starved_c) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_owner <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      pend_owner <= pend_owner_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  assign if_rvalid = (pend_owner == OWN_IF);
  assign d_rvalid  = (pend_owner == OWN_DLOAD);
  assign if_rdata  = mem_data_out;
  assign d_rdata   = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed vector table, reset/idle sequences, and a
// random phase checked against a grant/response scoreboard.
module tb_mem_arbiter;

  localparam int unsigned STARVE_MAX = 2;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_funct3;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_wren;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_data_out;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_funct3     (d_funct3),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .mem_wren     (mem_wren),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_funct3   (mem_funct3),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Synchronous-read memory: data one cycle after the address
  always @(posedge clk) mem_data_out <= data_fn(mem_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        is_if;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   m_cnt;

  // Scoreboard: predicts grants/mux each cycle, queues reads, checks responses
  always @(negedge clk or negedge reset) begin : monitor
    logic exp_if, exp_d, exp_ifv, exp_dv;
    rsp_t r;
    if (!reset) begin
      sb.delete();
      m_cnt = 0;
    end else if (clk == 1'b0) begin
      exp_if = if_req && (!d_req || m_cnt == STARVE_MAX);
      exp_d  = d_req && !exp_if;
      chk("sb_if_gnt", 32'(if_gnt), 32'(exp_if));
      chk("sb_d_gnt", 32'(d_gnt), 32'(exp_d));
      chk("sb_mem_wren", 32'(mem_wren), 32'(exp_d && d_we));
      chk("sb_mem_address", mem_address, exp_if ? if_addr : (exp_d ? d_addr : 32'd0));
      chk("sb_mem_data_in", mem_data_in, (!exp_if && exp_d) ? d_wdata : 32'd0);
      chk("sb_mem_funct3", 32'(mem_funct3),
          32'(exp_if ? 3'b010 : (exp_d ? d_funct3 : 3'b000)));
      exp_ifv = (sb.size() > 0) && sb[0].is_if;
      exp_dv  = (sb.size() > 0) && !sb[0].is_if;
      chk("sb_if_rvalid", 32'(if_rvalid), 32'(exp_ifv));
      chk("sb_d_rvalid", 32'(d_rvalid), 32'(exp_dv));
      if (sb.size() > 0) begin
        r = sb.pop_front();
        chk("sb_rdata", r.is_if ? if_rdata : d_rdata, r.data);
      end
      if (exp_if) sb.push_back('{is_if: 1'b1, data: data_fn(if_addr)});
      else if (exp_d && !d_we) sb.push_back('{is_if: 1'b0, data: data_fn(d_addr)});
      if (!if_req || exp_if) m_cnt = 0;
      else if (exp_d && m_cnt < STARVE_MAX) m_cnt++;
    end
  end

  typedef struct {
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [2:0]  d_f3;
    logic        e_ifg, e_dg, e_ifv, e_dv, e_wren;
    logic [31:0] e_addr, e_din;
    logic [2:0]  e_f3;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic dr, input logic we,
                              input logic [31:0] da, input logic [31:0] wd, input logic [2:0] f3,
                              input logic eig, input logic edg, input logic eiv, input logic edv,
                              input logic ewr, input logic [31:0] ea, input logic [31:0] ed,
                              input logic [2:0] ef3, input logic [31:0] erd);
    vec_t v;
    v.if_req = ir;  v.d_req = dr;  v.d_we = we;
    v.if_addr = 32'h10;  v.d_addr = da;  v.d_wdata = wd;  v.d_f3 = f3;
    v.e_ifg = eig;  v.e_dg = edg;  v.e_ifv = eiv;  v.e_dv = edv;  v.e_wren = ewr;
    v.e_addr = ea;  v.e_din = ed;  v.e_f3 = ef3;  v.e_rdata = erd;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    // fetch, conflict D/D/IF/D, store, back-to-back loads, drain
    vecs[0]  = mk(1, 0, 0, 32'h0,    32'h0,        3'd0, 1, 0, 0, 0, 0, 32'h10,   32'h0,        3'd2, 32'h0);
    vecs[1]  = mk(0, 0, 0, 32'h0,    32'h0,        3'd0, 0, 0, 1, 0, 0, 32'h0,    32'h0,        3'd0, 32'h0050_0093);
    vecs[2]  = mk(1, 1, 0, 32'h1000, 32'h0,        3'd4, 0, 1, 0, 0, 0, 32'h1000, 32'h0,        3'd4, 32'h0);
    vecs[3]  = mk(1, 1, 0, 32'h1000, 32'h0,        3'd4, 0, 1, 0, 1, 0, 32'h1000, 32'h0,        3'd4, data_fn(32'h1000));
    vecs[4]  = mk(1, 1, 0, 32'h1000, 32'h0,        3'd4, 1, 0, 0, 1, 0, 32'h10,   32'h0,        3'd2, data_fn(32'h1000));
    vecs[5]  = mk(1, 1, 0, 32'h1000, 32'h0,        3'd4, 0, 1, 1, 0, 0, 32'h1000, 32'h0,        3'd4, 32'h0050_0093);
    vecs[6]  = mk(0, 0, 0, 32'h0,    32'h0,        3'd0, 0, 0, 0, 1, 0, 32'h0,    32'h0,        3'd0, data_fn(32'h1000));
    vecs[7]  = mk(0, 1, 1, 32'hFFC,  32'hDEADBEEF, 3'd2, 0, 1, 0, 0, 1, 32'hFFC,  32'hDEADBEEF, 3'd2, 32'h0);
    vecs[8]  = mk(0, 1, 0, 32'h100,  32'h0,        3'd4, 0, 1, 0, 0, 0, 32'h100,  32'h0,        3'd4, 32'h0);
    vecs[9]  = mk(0, 1, 0, 32'h104,  32'h0,        3'd4, 0, 1, 0, 1, 0, 32'h104,  32'h0,        3'd4, data_fn(32'h100));
    vecs[10] = mk(0, 1, 0, 32'h108,  32'h0,        3'd4, 0, 1, 0, 1, 0, 32'h108,  32'h0,        3'd4, data_fn(32'h104));
    vecs[11] = mk(0, 0, 0, 32'h0,    32'h0,        3'd0, 0, 0, 0, 1, 0, 32'h0,    32'h0,        3'd0, data_fn(32'h108));
    vecs[12] = mk(0, 0, 0, 32'h0,    32'h0,        3'd0, 0, 0, 0, 0, 0, 32'h0,    32'h0,        3'd0, 32'h0);

    reset = 1'b0;  if_req = 1'b0;  if_addr = 32'h0;  d_req = 1'b0;  d_we = 1'b0;
    d_addr = 32'h0;  d_wdata = 32'h0;  d_funct3 = 3'd0;

    // Requests during reset must not be granted
    repeat (2) @(posedge clk);
    #1;
    if_req = 1'b1;  d_req = 1'b1;  d_we = 1'b1;  d_addr = 32'h44;
    #1;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_mem_wren", 32'(mem_wren), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_starve_cnt", 32'(dut.starve_cnt), 32'd0);
    if_req = 1'b0;  d_req = 1'b0;  d_we = 1'b0;  d_addr = 32'h0;
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if_req = vecs[i].if_req;  d_req = vecs[i].d_req;  d_we = vecs[i].d_we;
      if_addr = vecs[i].if_addr;  d_addr = vecs[i].d_addr;
      d_wdata = vecs[i].d_wdata;  d_funct3 = vecs[i].d_f3;
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(vecs[i].e_ifg));
      chk($sformatf("v%0d_d_gnt", i), 32'(d_gnt), 32'(vecs[i].e_dg));
      chk($sformatf("v%0d_if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].e_ifv));
      chk($sformatf("v%0d_d_rvalid", i), 32'(d_rvalid), 32'(vecs[i].e_dv));
      chk($sformatf("v%0d_mem_wren", i), 32'(mem_wren), 32'(vecs[i].e_wren));
      chk($sformatf("v%0d_mem_address", i), mem_address, vecs[i].e_addr);
      chk($sformatf("v%0d_mem_data_in", i), mem_data_in, vecs[i].e_din);
      chk($sformatf("v%0d_mem_funct3", i), 32'(mem_funct3), 32'(vecs[i].e_f3));
      if (vecs[i].e_ifv) chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_rdata);
      if (vecs[i].e_dv) chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_rdata);
      @(posedge clk);
      #1;
    end

    // Reset lands between a fetch grant and its response
    if_req = 1'b1;  if_addr = 32'h20;
    @(negedge clk);
    #1;
    chk("rmr_if_gnt", 32'(if_gnt), 32'd1);
    reset = 1'b0;  if_req = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rmr_if_rvalid_in_reset", 32'(if_rvalid), 32'd0);
      chk("rmr_d_rvalid_in_reset", 32'(d_rvalid), 32'd0);
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rmr_if_rvalid_release", 32'(if_rvalid), 32'd0);
    @(posedge clk);
    #1;
    chk("rmr_if_rvalid_no_grant", 32'(if_rvalid), 32'd0);
    if_req = 1'b1;  if_addr = 32'h10;
    #1;
    chk("rmr_new_if_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    chk("rmr_new_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("rmr_new_if_rdata", if_rdata, 32'h0050_0093);

    // Idle: everything quiet
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("idle_grants", 32'({if_gnt, d_gnt}), 32'd0);
      chk("idle_rvalids", 32'({if_rvalid, d_rvalid}), 32'd0);
      chk("idle_mem_wren", 32'(mem_wren), 32'd0);
      chk("idle_mem_address", mem_address, 32'd0);
      chk("idle_starve_cnt", 32'(dut.starve_cnt), 32'd0);
    end

    // Random traffic, data-heavy to exercise the starvation limit
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) begin
      if_req   = 1'($urandom_range(0, 1));
      d_req    = ($urandom_range(0, 3) != 0);
      d_we     = ($urandom_range(0, 3) == 0);
      if_addr  = 32'($urandom_range(0, 1023)) << 2;
      d_addr   = $urandom;
      d_wdata  = $urandom;
      d_funct3 = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
    end
    if_req = 1'b0;  d_req = 1'b0;  d_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
